alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle controller in front of the shared ALU (and/or/add/sub/shr/shl/ror/rol/mul/div/neg/not, 4-bit control, 64-bit result). It accepts one operation at a time over a valid/ready request port and drives the ALU control and operand inputs from internal registers. It holds those inputs stable for an op-dependent number of cycles, so the booth multiplier and non-restoring divider paths get multicycle timing. It then captures the 64-bit result into HI/LO registers and presents it on a valid/ready response port, flagging divide-by-zero and illegal opcodes without running the ALU.

## Interface
- REG_SIZE, 32, operand width; the result is 2*REG_SIZE.
- MUL_CYCLES, 4, number of EXEC cycles for op 1000; must be at least 1.
- DIV_CYCLES, 8, number of EXEC cycles for op 1001; must be at least 1.
- clock  in  1  single clock; all state changes on the rising edge.
- clear_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE with clear_n high.
- req_op  in  4  ALU opcode, encoded exactly as the ALU's control field.
- req_a, req_b  in  REG_SIZE  operands.
- alu_ctrl  out  4  to ALU ctrl_sig; registered.
- alu_a, alu_b  out  REG_SIZE  to ALU a/b inputs; registered.
- alu_c  in  2*REG_SIZE  ALU result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_hi, rsp_lo  out  REG_SIZE  result upper and lower halves.
- rsp_err  out  1  divide-by-zero or illegal opcode.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - A handshake occurs when req_valid and req_ready are both high at a clock edge.
  - On the handshake, latch req_op into alu_ctrl, req_a into alu_a and req_b into alu_b.
  - Illegal op (1100–1111), or op 1001 with req_b == 0: go directly to DONE. Set rsp_err=1 and rsp_hi=rsp_lo=0. The ALU result is never sampled.
  - Otherwise go to EXEC and load the counter with k-1, where k = MUL_CYCLES for 1000, DIV_CYCLES for 1001, and 1 for all other ops.
- EXEC:
  - alu_ctrl, alu_a and alu_b are held constant.
  - While the counter is nonzero, decrement it.
  - At the edge where the counter is 0: capture rsp_lo = alu_c[31:0] and clear rsp_err, then go to DONE.
  - In the same capture, rsp_hi = alu_c[63:32] for ops 1000 and 1001, and rsp_hi = 0 for all other ops. The ALU does not drive its upper half consistently for logic/shift/rotate ops.
- DONE:
  - rsp_valid=1.
  - rsp_hi, rsp_lo and rsp_err are held stable until rsp_ready is high at an edge, then go to IDLE.
  - rsp_valid is never withdrawn without that handshake.
- Requests are not accepted in EXEC or DONE (req_ready=0). There is no same-cycle response-to-request overlap: req_ready rises on the cycle after the response handshake.
- Counter width: sized to hold max(MUL_CYCLES, DIV_CYCLES)-1. It does not wrap; it is reloaded only on entry to EXEC.

## Timing
- Reset (clear_n low at an edge):
  - State goes to IDLE.
  - alu_ctrl=0000, alu_a=0, alu_b=0, rsp_hi=0, rsp_lo=0, rsp_err=0, rsp_valid=0, busy=0, counter=0.
  - req_ready is 0 while clear_n is low.
- Reset mid-EXEC or mid-DONE aborts the operation. No response is produced and the pending result is discarded.
- Latency: request accepted at edge N.
  - Normal op: rsp_valid is high after edge N+k. Single-cycle ops give N+1, mul gives N+MUL_CYCLES, div gives N+DIV_CYCLES.
  - Error path: rsp_valid is high after edge N+1.
- Response accepted at edge M: rsp_valid=0 and req_ready=1 after M. The earliest next accept is M+1.
- Throughput for single-cycle ops with rsp_ready tied high: one op per 3 cycles.
- alu_ctrl, alu_a and alu_b change only at a request-accept edge or reset.
- busy = (state != IDLE) and is registered with the state.

## Test plan
- Add 5 + 7 (op 0010), rsp_ready=1, accept at edge N -> rsp_valid after N+1, rsp_lo=0x0000000C, rsp_hi=0, rsp_err=0, req_ready=1 after N+2.
- Mul with MUL_CYCLES=4, a=0xFFFFFFFF, b=2 (op 1000) -> alu inputs stable for 4 cycles, rsp_valid after N+4, rsp_hi=0xFFFFFFFF, rsp_lo=0xFFFFFFFE.
- Div with b=0 (op 1001), and separately op 1101 -> rsp_valid after N+1, rsp_err=1, rsp_hi=rsp_lo=0. alu_c is forced to 0xDEADBEEF_DEADBEEF to prove the result is not sampled.
- Rotate-left 0x80000001 by 1 (op 0111), rsp_ready held low for 5 cycles -> rsp_lo=0x00000003 and rsp_hi=0 stable all 5 cycles. req_valid asserted throughout is not accepted until the cycle after rsp_ready.
- clear_n pulsed low during the 2nd EXEC cycle of a div -> all outputs at reset values next edge, no rsp_valid pulse, and a new add request is accepted immediately after clear_n is released.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller in front of the shared ALU.
// Accepts one operation over a valid/ready request port and holds the ALU
// control and operands in registers for an op-dependent number of cycles.
// It then captures the 64-bit result into HI/LO and offers it on a
// valid/ready response port. Divide-by-zero and illegal opcodes are
// answered with an error response and never run the ALU.
module alu_sequencer #(
    parameter int REG_SIZE   = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [REG_SIZE-1:0]   req_a,
    input  logic [REG_SIZE-1:0]   req_b,
    output logic [3:0]            alu_ctrl,
    output logic [REG_SIZE-1:0]   alu_a,
    output logic [REG_SIZE-1:0]   alu_b,
    input  logic [2*REG_SIZE-1:0] alu_c,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [REG_SIZE-1:0]   rsp_hi,
    output logic [REG_SIZE-1:0]   rsp_lo,
    output logic                  rsp_err,
    output logic                  busy
);

    // Counter only ever needs to hold max(MUL_CYCLES, DIV_CYCLES)-1.
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [3:0]       OP_MUL   = 4'b1000;
    localparam logic [3:0]       OP_DIV   = 4'b1001;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_cnt;
    logic [3:0]            r_alu_ctrl;
    logic [REG_SIZE-1:0]   r_alu_a;
    logic [REG_SIZE-1:0]   r_alu_b;
    logic [REG_SIZE-1:0]   r_rsp_hi;
    logic [REG_SIZE-1:0]   r_rsp_lo;
    logic                  r_rsp_err;

    logic                  w_req_ready;
    logic                  w_rsp_valid;
    logic                  w_req_fire;
    logic                  w_op_illegal;
    logic                  w_div_zero;
    logic                  w_reject;
    logic                  w_cnt_zero;
    logic                  w_wide_op;
    logic [CNT_W-1:0]      w_cnt_load;

    // Request decode: handshake, error detection and EXEC counter preload.
    always_comb begin
        w_req_fire   = req_valid && w_req_ready;
        w_op_illegal = (req_op[3:2] == 2'b11);
        w_div_zero   = (req_op == OP_DIV) && (req_b == '0);
        w_reject     = w_op_illegal || w_div_zero;
        w_cnt_zero   = (r_cnt == '0);
        // Only mul/div drive a meaningful upper result half.
        w_wide_op    = (r_alu_ctrl == OP_MUL) || (r_alu_ctrl == OP_DIV);
        case (req_op)
            OP_MUL:  w_cnt_load = MUL_LOAD;
            OP_DIV:  w_cnt_load = DIV_LOAD;
            default: w_cnt_load = '0;
        endcase
    end

    // State register; busy is registered alongside it from the next state.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_fire) begin
                    w_next_state = w_reject ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_cnt_zero) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: request ready only in IDLE out of reset, response valid in DONE.
    always_comb begin
        w_req_ready = (r_state == S_IDLE) && clear_n;
        w_rsp_valid = (r_state == S_DONE);
    end

    // Operand latch, cycle counter and result capture.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_alu_ctrl <= 4'b0000;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_cnt      <= '0;
            r_rsp_hi   <= '0;
            r_rsp_lo   <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_fire) begin
                        r_alu_ctrl <= req_op;
                        r_alu_a    <= req_a;
                        r_alu_b    <= req_b;
                        if (w_reject) begin
                            // Error response: the ALU result is never looked at.
                            r_rsp_hi  <= '0;
                            r_rsp_lo  <= '0;
                            r_rsp_err <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_load;
                        end
                    end
                end
                S_EXEC: begin
                    if (w_cnt_zero) begin
                        r_rsp_lo  <= alu_c[REG_SIZE-1:0];
                        r_rsp_hi  <= w_wide_op ? alu_c[2*REG_SIZE-1:REG_SIZE] : '0;
                        r_rsp_err <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = w_rsp_valid;
    assign alu_ctrl  = r_alu_ctrl;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_hi    = r_rsp_hi;
    assign rsp_lo    = r_rsp_lo;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule
